// File: rtl/ft2232h_pkg.sv
// Shared definitions for the FT2232H synchronous-FIFO transmit arbiter:
// FSM encoding, bus width and header construction.
package ft2232h_pkg;

  localparam int ADBUS_W = 8;
  localparam int CH_W    = 2;

  localparam logic [ADBUS_W-1:0] HDR_TAG_DEFAULT = 8'hA0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_t;

  // Header identifies the source channel in its low bits.
  function automatic logic [ADBUS_W-1:0] hdr_byte(input logic [ADBUS_W-1:0] tag,
                                                  input logic [CH_W-1:0]    ch);
    return tag | {{(ADBUS_W-CH_W){1'b0}}, ch};
  endfunction

endpackage

// File: rtl/ft2232h_rr_arbiter.sv
// Combinational round-robin picker: the search starts one past the last
// granted channel and wraps at N_CH.
module ft2232h_rr_arbiter
  import ft2232h_pkg::*;
#(
  parameter int N_CH = 4
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] last,
  output logic [N_CH-1:0] gnt_oh,
  output logic [CH_W-1:0] gnt_idx,
  output logic            gnt_any
);

  logic [2*N_CH-1:0] req_dbl;
  logic [N_CH-1:0]   req_rot;
  logic [CH_W:0]     start;
  int                pos;
  int                idx;

  // Rotating a doubled copy puts channel last+1 at bit 0 without a modulo.
  assign start   = {1'b0, last} + (CH_W+1)'(1);
  assign req_dbl = {req, req};
  assign req_rot = N_CH'(req_dbl >> start);
  assign gnt_any = |req;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block leaves a value held and no latch is inferred.
    pos     = 0;
    idx     = 0;
    gnt_idx = '0;
    gnt_oh  = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (req_rot[k]) pos = k;
    end
    idx = int'(start) + pos;
    if (idx >= N_CH) idx = idx - N_CH;
    if (gnt_any) begin
      gnt_idx = CH_W'(idx);
      gnt_oh  = N_CH'(1) << idx;
    end
  end

endmodule

// File: rtl/ft2232h_tx_arbiter.sv
// Multiplexes N_CH byte streams into headered bursts on the FT2232H
// synchronous FIFO write port through a single output holding register.
module ft2232h_tx_arbiter
  import ft2232h_pkg::*;
#(
  parameter int                  N_CH      = 4,
  parameter int                  BURST_LEN = 16,
  parameter logic [ADBUS_W-1:0]  HDR_TAG   = HDR_TAG_DEFAULT
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    enable_i,
  input  logic [N_CH-1:0]         req_avail_i,
  input  logic [N_CH-1:0]         req_valid_i,
  input  logic [ADBUS_W*N_CH-1:0] req_data_i,
  output logic [N_CH-1:0]         req_ready_o,
  input  logic                    txe_i,
  output logic                    wr_o,
  output logic                    oe_o,
  output logic [ADBUS_W-1:0]      adbus_o,
  output logic                    busy_o,
  output logic [CH_W-1:0]         cur_ch_o
);

  localparam int              CNT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

  state_t              state_q, state_d;
  logic [ADBUS_W-1:0]  data_r;
  logic                vld_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [CH_W-1:0]     cur_ch_r, last_ch_r;
  logic [N_CH-1:0]     cur_oh_r;

  logic                xfer, load_ok;
  logic                grant, load_hdr, load_pay, cnt_last;
  logic                sel_valid;
  logic [ADBUS_W-1:0]  sel_data;
  logic [N_CH-1:0]     gnt_oh;
  logic [CH_W-1:0]     gnt_idx;
  logic                gnt_any;

  ft2232h_rr_arbiter #(.N_CH(N_CH)) u_rr (
    .req     (req_avail_i),
    .last    (last_ch_r),
    .gnt_oh  (gnt_oh),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // A byte leaves the holding register only when the FIFO has room; the
  // register may refill on the same edge it drains.
  assign xfer     = vld_r & ~txe_i;
  assign load_ok  = ~vld_r | xfer;
  assign wr_o     = ~xfer;
  assign oe_o     = vld_r;
  assign adbus_o  = data_r;
  assign cur_ch_o = cur_ch_r;
  assign cnt_last = (cnt_r == CNT_LAST);

  assign sel_valid = |(req_valid_i & cur_oh_r);
  always_comb begin
    sel_data = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (cur_oh_r[c]) sel_data = sel_data | req_data_i[ADBUS_W*c +: ADBUS_W];
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (!rst_i) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (enable_i && gnt_any)  state_d = ST_HEADER;
      ST_HEADER:  if (load_ok)              state_d = ST_PAYLOAD;
      ST_PAYLOAD: if (load_pay && cnt_last) state_d = ST_IDLE;
      default:                              state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    grant       = 1'b0;
    load_hdr    = 1'b0;
    load_pay    = 1'b0;
    busy_o      = 1'b0;
    req_ready_o = '0;
    unique case (state_q)
      ST_IDLE:    grant = enable_i & gnt_any;
      ST_HEADER: begin
        busy_o   = 1'b1;
        load_hdr = load_ok;
      end
      ST_PAYLOAD: begin
        busy_o      = 1'b1;
        req_ready_o = cur_oh_r & {N_CH{load_ok}};
        load_pay    = load_ok & sel_valid;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      data_r    <= '0;
      vld_r     <= 1'b0;
      cnt_r     <= '0;
      cur_ch_r  <= '0;
      cur_oh_r  <= N_CH'(1);
      last_ch_r <= CH_W'(N_CH - 1);
    end else begin
      // Channel is latched at grant; later req_avail_i changes cannot move it.
      if (grant) begin
        cur_ch_r <= gnt_idx;
        cur_oh_r <= gnt_oh;
      end
      if (load_hdr) begin
        data_r <= hdr_byte(HDR_TAG, cur_ch_r);
        vld_r  <= 1'b1;
        cnt_r  <= '0;
      end else if (load_pay) begin
        data_r <= sel_data;
        vld_r  <= 1'b1;
        cnt_r  <= cnt_r + 1'b1;
        if (cnt_last) last_ch_r <= cur_ch_r;
      end else if (xfer) begin
        vld_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ft2232h_tx_arbiter.sv
// Self-checking bench: per-channel byte sources, a write monitor on ADBUS and
// a burst-level round-robin reference model.
module tb_ft2232h_tx_arbiter;

  localparam int         N_CH      = 4;
  localparam int         BURST_LEN = 16;
  localparam int         BW        = BURST_LEN + 1;
  localparam logic [7:0] HDR       = 8'hA0;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        enable_i = 1'b0;
  logic        txe_i = 1'b1;
  logic [3:0]  req_avail_i = '0;
  logic [3:0]  req_valid_i = '0;
  logic [31:0] req_data_i;
  logic [3:0]  req_ready_o;
  logic        wr_o, oe_o, busy_o;
  logic [7:0]  adbus_o;
  logic [1:0]  cur_ch_o;

  ft2232h_tx_arbiter #(.N_CH(N_CH), .BURST_LEN(BURST_LEN), .HDR_TAG(HDR)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .enable_i    (enable_i),
    .req_avail_i (req_avail_i),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_ready_o (req_ready_o),
    .txe_i       (txe_i),
    .wr_o        (wr_o),
    .oe_o        (oe_o),
    .adbus_o     (adbus_o),
    .busy_o      (busy_o),
    .cur_ch_o    (cur_ch_o)
  );

  always #8 clk_i = ~clk_i;

  int n_pass = 0;
  int n_total = 0;

  // Channel sources: channel c emits ch_base(c) + running index.
  function automatic logic [7:0] ch_base(input int c);
    return 8'(c * 64);
  endfunction

  logic [7:0] src_seq [4];
  logic [3:0] take_q = '0;

  always_comb begin
    req_data_i = '0;
    for (int c = 0; c < 4; c++) req_data_i[8*c +: 8] = ch_base(c) + src_seq[c];
  end

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int c = 0; c < 4; c++) src_seq[c] <= 8'd0;
    end else begin
      for (int c = 0; c < 4; c++) if (take_q[c]) src_seq[c] <= src_seq[c] + 8'd1;
    end
  end

  // Write monitor, sampled mid-cycle.
  logic [7:0] obs [$];
  int run_len = 0, max_run = 0, bad_wr = 0;

  always @(negedge clk_i) begin
    take_q = req_ready_o & req_valid_i;
    if (rst_i && !wr_o) begin
      obs.push_back(adbus_o);
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
    if (!wr_o && txe_i) bad_wr++;
  end

  // Reference model: whole bursts chosen round-robin over the avail mask.
  int         m_last;
  int         m_seq [4];
  logic [7:0] exp_q [$];

  task automatic model_reset();
    m_last = 3;
    for (int c = 0; c < 4; c++) m_seq[c] = 0;
    exp_q.delete();
  endtask

  task automatic model_bursts(input logic [3:0] avail, input int n);
    for (int b = 0; b < n; b++) begin
      int ch = -1;
      for (int i = 1; i <= 4; i++) begin
        int c = (m_last + i) % 4;
        if (ch < 0 && avail[c]) ch = c;
      end
      if (ch < 0) return;
      exp_q.push_back(HDR | 8'(ch));
      for (int k = 0; k < BURST_LEN; k++) begin
        exp_q.push_back(ch_base(ch) + 8'(m_seq[ch]));
        m_seq[ch]++;
      end
      m_last = ch;
    end
  endtask

  function automatic int stream_diff();
    int n = (obs.size() > exp_q.size()) ? obs.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (i >= obs.size() || i >= exp_q.size()) return i;
      if (obs[i] !== exp_q[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [7:0] obs_at(input int i);
    return (i >= 0 && i < obs.size()) ? obs[i] : 8'hxx;
  endfunction

  function automatic logic [7:0] exp_at(input int i);
    return (i >= 0 && i < exp_q.size()) ? exp_q[i] : 8'hxx;
  endfunction

  task automatic do_reset();
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    req_avail_i = '0;
    req_valid_i = '0;
    enable_i = 1'b0;
    txe_i = 1'b1;
    obs.delete();
    max_run = 0;
    run_len = 0;
    bad_wr = 0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;
  endtask

  // mode 0: steady, 1: TXE# toggles every cycle, 2: random TXE# and valid.
  task automatic run_bursts(input logic [3:0] avail, input int n, input int mode);
    int  rises = 0;
    bit  prev = 1'b0;
    int  target = obs.size() + n * BW;
    @(posedge clk_i); #1;
    req_avail_i = avail;
    enable_i = 1'b1;
    req_valid_i = 4'hF;
    txe_i = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk_i); #1;
      if (busy_o && !prev) rises++;
      prev = busy_o;
      if (rises >= n && !busy_o && obs.size() >= target) break;
      @(posedge clk_i); #1;
      if (rises >= n) req_avail_i = '0;
      if (mode == 1) txe_i = ~txe_i;
      if (mode == 2) begin
        txe_i = ($urandom_range(0, 2) == 0);
        req_valid_i = 4'($urandom);
      end
    end
    @(posedge clk_i); #1;
    txe_i = 1'b0;
    req_valid_i = 4'hF;
    repeat (3) @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    #1;
    n_total++; if (wr_o !== 1'b1) $display("FAIL reset_wr: got %b want 1", wr_o); else n_pass++;
    n_total++; if (oe_o !== 1'b0) $display("FAIL reset_oe: got %b want 0", oe_o); else n_pass++;
    n_total++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_o); else n_pass++;
    n_total++; if (req_ready_o !== 4'b0) $display("FAIL reset_ready: got %b want 0000", req_ready_o); else n_pass++;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(negedge clk_i);
    n_total++; if (cur_ch_o !== 2'd0) $display("FAIL reset_cur_ch: got %0d want 0", cur_ch_o); else n_pass++;
    n_total++; if (adbus_o !== 8'h00) $display("FAIL reset_adbus: got %h want 00", adbus_o); else n_pass++;
    n_total++; if (wr_o !== 1'b1) $display("FAIL reset_wr_after: got %b want 1", wr_o); else n_pass++;
  endtask

  task automatic test_single_burst();
    int d;
    do_reset();
    model_bursts(4'b0001, 1);
    run_bursts(4'b0001, 1, 0);
    d = stream_diff();
    n_total++;
    if (d < 0) n_pass++;
    else $display("FAIL single_stream: byte %0d got %h want %h (writes %0d want %0d)",
                  d, obs_at(d), exp_at(d), obs.size(), exp_q.size());
    n_total++; if (max_run !== BW) $display("FAIL single_consecutive: got %0d want %0d", max_run, BW); else n_pass++;
    n_total++; if (oe_o !== 1'b0) $display("FAIL single_oe_idle: got %b want 0", oe_o); else n_pass++;
    n_total++; if (busy_o !== 1'b0) $display("FAIL single_busy_idle: got %b want 0", busy_o); else n_pass++;
  endtask

  task automatic test_round_robin();
    int d;
    do_reset();
    model_bursts(4'hF, 5);
    run_bursts(4'hF, 5, 0);
    d = stream_diff();
    n_total++;
    if (d < 0) n_pass++;
    else $display("FAIL rr_stream: byte %0d got %h want %h (writes %0d want %0d)",
                  d, obs_at(d), exp_at(d), obs.size(), exp_q.size());
    n_total++; if (max_run !== BW) $display("FAIL rr_gap: longest write run %0d want %0d", max_run, BW); else n_pass++;
    n_total++; if (cur_ch_o !== 2'(m_last)) $display("FAIL rr_cur_ch: got %0d want %0d", cur_ch_o, m_last); else n_pass++;
  endtask

  task automatic test_txe_toggle();
    int d;
    do_reset();
    model_bursts(4'b0001, 1);
    run_bursts(4'b0001, 1, 1);
    d = stream_diff();
    n_total++;
    if (d < 0) n_pass++;
    else $display("FAIL txe_stream: byte %0d got %h want %h (writes %0d want %0d)",
                  d, obs_at(d), exp_at(d), obs.size(), exp_q.size());
    n_total++; if (bad_wr !== 0) $display("FAIL txe_wr_blocked: %0d writes with TXE# high, want 0", bad_wr); else n_pass++;
  endtask

  task automatic test_valid_stall();
    int d;
    bit hit = 1'b0;
    do_reset();
    model_bursts(4'b0100, 1);
    @(posedge clk_i); #1;
    req_avail_i = 4'b0100;
    enable_i = 1'b1;
    req_valid_i = 4'hF;
    txe_i = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(posedge clk_i); #1;
      if (busy_o) req_avail_i = '0;
      if (src_seq[2] == 8'd8) begin
        hit = 1'b1;
        break;
      end
    end
    n_total++; if (!hit) $display("FAIL stall_reach_byte7: consumed %0d want 8", src_seq[2]); else n_pass++;
    req_valid_i[2] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      n_total++; if (busy_o !== 1'b1) $display("FAIL stall_busy: cycle %0d got %b want 1", i, busy_o); else n_pass++;
      if (i > 0) begin
        n_total++; if (wr_o !== 1'b1) $display("FAIL stall_no_write: cycle %0d wr %b want 1", i, wr_o); else n_pass++;
      end
      @(posedge clk_i); #1;
    end
    req_valid_i = 4'hF;
    for (int cyc = 0; cyc < 200 && obs.size() < BW; cyc++) @(posedge clk_i);
    repeat (3) @(posedge clk_i);
    #1;
    d = stream_diff();
    n_total++;
    if (d < 0) n_pass++;
    else $display("FAIL stall_stream: byte %0d got %h want %h (writes %0d want %0d)",
                  d, obs_at(d), exp_at(d), obs.size(), exp_q.size());
  endtask

  task automatic test_reset_mid();
    int d;
    int bad = 0;
    do_reset();
    model_bursts(4'b0010, 1);
    @(posedge clk_i); #1;
    req_avail_i = 4'b0010;
    enable_i = 1'b1;
    req_valid_i = 4'hF;
    txe_i = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk_i); #1;
      if (busy_o) req_avail_i = '0;
      if (obs.size() >= 6) break;
    end
    for (int i = 0; i < 6; i++) if (obs_at(i) !== exp_at(i)) bad++;
    n_total++;
    if (bad != 0 || obs.size() != 6)
      $display("FAIL midrst_prefix: %0d wrong of %0d writes, want 0 wrong of 6", bad, obs.size());
    else n_pass++;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    #1;
    n_total++; if (wr_o !== 1'b1) $display("FAIL midrst_wr: got %b want 1", wr_o); else n_pass++;
    n_total++; if (oe_o !== 1'b0) $display("FAIL midrst_oe: got %b want 0", oe_o); else n_pass++;
    n_total++; if (busy_o !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy_o); else n_pass++;
    n_total++; if (req_ready_o !== 4'b0) $display("FAIL midrst_ready: got %b want 0000", req_ready_o); else n_pass++;
    obs.delete();
    model_reset();
    req_avail_i = '0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;
    model_bursts(4'b0001, 1);
    run_bursts(4'b0001, 1, 0);
    d = stream_diff();
    n_total++;
    if (d < 0) n_pass++;
    else $display("FAIL midrst_restart: byte %0d got %h want %h (writes %0d want %0d)",
                  d, obs_at(d), exp_at(d), obs.size(), exp_q.size());
  endtask

  task automatic test_enable();
    int d;
    do_reset();
    model_bursts(4'b1000, 1);
    @(posedge clk_i); #1;
    req_avail_i = 4'b1000;
    enable_i = 1'b1;
    req_valid_i = 4'hF;
    txe_i = 1'b0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      @(negedge clk_i);
      if (busy_o) break;
    end
    @(posedge clk_i); #1;
    enable_i = 1'b0;
    req_avail_i = 4'b0001;
    repeat (60) @(posedge clk_i);
    #1;
    d = stream_diff();
    n_total++;
    if (d < 0) n_pass++;
    else $display("FAIL enable_hold: byte %0d got %h want %h (writes %0d want %0d)",
                  d, obs_at(d), exp_at(d), obs.size(), exp_q.size());
    n_total++; if (busy_o !== 1'b0) $display("FAIL enable_no_grant: busy %b want 0", busy_o); else n_pass++;
    model_bursts(4'b0001, 1);
    run_bursts(4'b0001, 1, 0);
    d = stream_diff();
    n_total++;
    if (d < 0) n_pass++;
    else $display("FAIL enable_resume: byte %0d got %h want %h (writes %0d want %0d)",
                  d, obs_at(d), exp_at(d), obs.size(), exp_q.size());
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      int         d;
      int         n = $urandom_range(2, 4);
      logic [3:0] avail = 4'($urandom_range(1, 15));
      do_reset();
      model_bursts(avail, n);
      run_bursts(avail, n, 2);
      d = stream_diff();
      n_total++;
      if (d < 0) n_pass++;
      else $display("FAIL random_stream[%0d] avail=%b: byte %0d got %h want %h (writes %0d want %0d)",
                    it, avail, d, obs_at(d), exp_at(d), obs.size(), exp_q.size());
      n_total++; if (bad_wr !== 0) $display("FAIL random_txe[%0d]: %0d writes with TXE# high", it, bad_wr); else n_pass++;
      n_total++; if (cur_ch_o !== 2'(m_last)) $display("FAIL random_cur_ch[%0d]: got %0d want %0d", it, cur_ch_o, m_last); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_txe_toggle();
    test_valid_stall();
    test_reset_mid();
    test_enable();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
